// File: rtl/thermal_covert_receiver.sv
// Thermal covert-channel receiver: windows ring-oscillator edge counts, calibrates a
// cold baseline, then majority-decodes start-framed bytes sent as hot/cold bursts.
module thermal_covert_receiver #(
  parameter int unsigned WINDOW_CYCLES   = 1024,
  parameter int unsigned COUNT_W         = 16,
  parameter int unsigned SAMPLES_PER_BIT = 4,
  parameter int unsigned CAL_WINDOWS     = 4,
  parameter int unsigned MARGIN          = 8,
  parameter int unsigned FRAME_BITS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  ro_in,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic [COUNT_W-1:0]    baseline,
  output logic [COUNT_W-1:0]    sample_count,
  output logic                  busy,
  output logic [7:0]            leds
);

  localparam int unsigned WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned CAL_LOG2 = $clog2(CAL_WINDOWS);
  localparam int unsigned CAL_CW   = (CAL_LOG2 > 0) ? CAL_LOG2 : 1;
  localparam int unsigned SUM_W    = COUNT_W + CAL_LOG2;
  localparam int unsigned SUB_W    = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int unsigned HOT_W    = $clog2(SAMPLES_PER_BIT + 1);
  localparam int unsigned BIT_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CAL_CW-1:0]  CAL_LAST  = CAL_CW'(CAL_WINDOWS - 1);
  localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(SAMPLES_PER_BIT - 1);
  localparam logic [SUB_W-1:0]   SKIP_LAST = SUB_W'((SAMPLES_PER_BIT > 1) ? SAMPLES_PER_BIT - 2 : 0);
  localparam logic [HOT_W-1:0]   HALF      = HOT_W'(SAMPLES_PER_BIT / 2);
  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [COUNT_W-1:0] MARGIN_C  = COUNT_W'(MARGIN);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CALIBRATE = 3'd1,
    ST_HUNT      = 3'd2,
    ST_RECEIVE   = 3'd3,
    ST_STOP      = 3'd4
  } state_t;

  function automatic logic [7:0] to_leds(input logic [FRAME_BITS-1:0] d);
    logic [FRAME_BITS+7:0] wide;
    wide = {8'd0, d};
    return wide[7:0];
  endfunction

  state_t                state_r;
  logic                  ro_meta_r, ro_sync_r, ro_prev_r;
  logic [WIN_W-1:0]      win_cnt_r;
  logic [COUNT_W-1:0]    edge_cnt_r;
  logic                  win_done_r;
  logic [SUM_W-1:0]      cal_sum_r;
  logic [CAL_CW-1:0]     cal_cnt_r;
  logic                  found_r;
  logic [SUB_W-1:0]      sub_cnt_r;
  logic [HOT_W-1:0]      hot_cnt_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic [FRAME_BITS-1:0] data_out_r;
  logic [7:0]            leds_r;
  logic                  data_valid_r, frame_error_r, busy_r;
  logic [COUNT_W-1:0]    baseline_r, sample_count_r;

  logic                  edge_s;
  logic [COUNT_W-1:0]    edge_total_s;
  logic [COUNT_W-1:0]    threshold_s;
  logic                  hot_s;
  logic [HOT_W-1:0]      hot_sum_s;
  logic                  bit_s;
  logic                  sub_last_s;
  logic [SUM_W-1:0]      cal_sum_s;
  logic [FRAME_BITS-1:0] shift_next_s;

  assign data_out     = data_out_r;
  assign data_valid   = data_valid_r;
  assign frame_error  = frame_error_r;
  assign baseline     = baseline_r;
  assign sample_count = sample_count_r;
  assign busy         = busy_r;
  assign leds         = leds_r;

  // Two-flop synchronizer on the RO plus a delay flop for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ro_meta_r <= 1'b0;
      ro_sync_r <= 1'b0;
      ro_prev_r <= 1'b0;
    end else begin
      ro_meta_r <= ro_in;
      ro_sync_r <= ro_meta_r;
      ro_prev_r <= ro_sync_r;
    end
  end

  // Edge total, hot classification and per-bit majority vote
  always_comb begin
    edge_s       = ro_sync_r & ~ro_prev_r;
    edge_total_s = edge_cnt_r;
    if (edge_s && (edge_cnt_r != COUNT_MAX)) begin
      edge_total_s = edge_cnt_r + COUNT_W'(1);
    end else begin
      edge_total_s = edge_cnt_r;
    end
    threshold_s = '0;
    if (baseline_r > MARGIN_C) begin
      threshold_s = baseline_r - MARGIN_C;
    end else begin
      threshold_s = '0;
    end
    hot_s        = (sample_count_r < threshold_s);
    hot_sum_s    = hot_cnt_r + HOT_W'(hot_s);
    bit_s        = (hot_sum_s > HALF);
    sub_last_s   = (sub_cnt_r == SUB_LAST);
    cal_sum_s    = cal_sum_r + SUM_W'(sample_count_r);
    shift_next_s = (shift_r << 1) | FRAME_BITS'(bit_s);
  end

  // Measurement window: counts RO edges and latches the total at the terminal cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_r      <= '0;
      edge_cnt_r     <= '0;
      win_done_r     <= 1'b0;
      sample_count_r <= '0;
    end else if (!enable || (state_r == ST_IDLE)) begin
      win_cnt_r  <= '0;
      edge_cnt_r <= '0;
      win_done_r <= 1'b0;
    end else if (win_cnt_r == WIN_LAST) begin
      sample_count_r <= edge_total_s;
      edge_cnt_r     <= '0;
      win_cnt_r      <= '0;
      win_done_r     <= 1'b1;
    end else begin
      edge_cnt_r <= edge_total_s;
      win_cnt_r  <= win_cnt_r + WIN_W'(1);
      win_done_r <= 1'b0;
    end
  end

  // Receiver FSM: calibrate, hunt for the start burst, decode bits, check the stop bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cal_sum_r     <= '0;
      cal_cnt_r     <= '0;
      found_r       <= 1'b0;
      sub_cnt_r     <= '0;
      hot_cnt_r     <= '0;
      bit_cnt_r     <= '0;
      shift_r       <= '0;
      data_out_r    <= '0;
      leds_r        <= 8'd0;
      data_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      busy_r        <= 1'b0;
      baseline_r    <= '0;
    end else if (!enable) begin
      // data_out/leds deliberately keep the last good frame across a disable
      state_r       <= ST_IDLE;
      cal_sum_r     <= '0;
      cal_cnt_r     <= '0;
      found_r       <= 1'b0;
      sub_cnt_r     <= '0;
      hot_cnt_r     <= '0;
      bit_cnt_r     <= '0;
      shift_r       <= '0;
      data_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      busy_r        <= 1'b0;
      baseline_r    <= '0;
    end else begin
      data_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r   <= ST_CALIBRATE;
          busy_r    <= 1'b1;
          cal_sum_r <= '0;
          cal_cnt_r <= '0;
        end
        ST_CALIBRATE: begin
          if (win_done_r) begin
            if (cal_cnt_r == CAL_LAST) begin
              baseline_r <= COUNT_W'(cal_sum_s >> CAL_LOG2);
              state_r    <= ST_HUNT;
              busy_r     <= 1'b0;
              cal_sum_r  <= '0;
              cal_cnt_r  <= '0;
              found_r    <= 1'b0;
              sub_cnt_r  <= '0;
            end else begin
              cal_sum_r <= cal_sum_s;
              cal_cnt_r <= cal_cnt_r + CAL_CW'(1);
            end
          end
        end
        ST_HUNT: begin
          if (win_done_r) begin
            if (!found_r) begin
              if (hot_s) begin
                sub_cnt_r <= '0;
                if (SAMPLES_PER_BIT == 1) begin
                  state_r   <= ST_RECEIVE;
                  busy_r    <= 1'b1;
                  hot_cnt_r <= '0;
                  bit_cnt_r <= '0;
                end else begin
                  found_r <= 1'b1;
                end
              end
            end else if (sub_cnt_r == SKIP_LAST) begin
              state_r   <= ST_RECEIVE;
              busy_r    <= 1'b1;
              found_r   <= 1'b0;
              sub_cnt_r <= '0;
              hot_cnt_r <= '0;
              bit_cnt_r <= '0;
            end else begin
              sub_cnt_r <= sub_cnt_r + SUB_W'(1);
            end
          end
        end
        ST_RECEIVE: begin
          if (win_done_r) begin
            if (sub_last_s) begin
              shift_r   <= shift_next_s;
              hot_cnt_r <= '0;
              sub_cnt_r <= '0;
              if (bit_cnt_r == BIT_LAST) begin
                state_r   <= ST_STOP;
                bit_cnt_r <= '0;
              end else begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              end
            end else begin
              sub_cnt_r <= sub_cnt_r + SUB_W'(1);
              hot_cnt_r <= hot_sum_s;
            end
          end
        end
        ST_STOP: begin
          if (win_done_r) begin
            if (sub_last_s) begin
              hot_cnt_r <= '0;
              sub_cnt_r <= '0;
              state_r   <= ST_HUNT;
              busy_r    <= 1'b0;
              if (bit_s) begin
                frame_error_r <= 1'b1;
              end else begin
                data_out_r   <= shift_r;
                leds_r       <= to_leds(shift_r);
                data_valid_r <= 1'b1;
              end
            end else begin
              sub_cnt_r <= sub_cnt_r + SUB_W'(1);
              hot_cnt_r <= hot_sum_s;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
